// File: rtl/rotl_share_arbiter_pkg.sv
// Shared types and helpers for the round-robin rotate-left sharing block.
package rotl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int SHAMT_W_DEF = 4;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result++;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rotl_share_arbiter_if.sv
// Requester and result handshake bundle between clients and the shared rotate block.
interface rotl_share_arbiter_if
  import rotl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int ID_W    = clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ*SHAMT_W-1:0] req_shamt;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       res_valid;
  logic [DATA_W-1:0]          res_data;
  logic [ID_W-1:0]            res_id;
  logic                       res_ready;
  logic                       busy;

  modport master (
    output req_valid, req_data, req_shamt, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_shamt, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/rotl_share_arbiter_unit.sv
// Combinational DATA_W-bit rotate-left; a zero amount passes the operand through.
module rotl_unit
  import rotl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic [DATA_W-1:0]  op,
  input  logic [SHAMT_W-1:0] sh,
  output logic [DATA_W-1:0]  res
);

  // Shifting the doubled operand brings the wrapped bits into the upper half.
  assign res = DATA_W'(({op, op} << sh) >> DATA_W);

endmodule

// File: rtl/rotl_share_arbiter.sv
// Round-robin arbiter feeding one shared rotate-left unit with a registered, ID-tagged result.
module rotl_share_arbiter
  import rotl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst_n,
  rotl_share_arbiter_if.slave bus
);

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [DATA_W-1:0]   op_reg;
  logic [SHAMT_W-1:0]  sh_reg;
  logic [ID_W-1:0]     id_reg;
  logic [DATA_W-1:0]   res_data_reg;
  logic [ID_W-1:0]     res_id_reg;
  logic [DATA_W-1:0]   rot_res;
  logic                can_accept;
  logic                accept;
  logic [NUM_REQ-1:0]  grant_vec;
  logic [ID_W-1:0]     grant_idx;

  logic [DATA_W-1:0]  data_arr  [NUM_REQ];
  logic [SHAMT_W-1:0] shamt_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi]  = bus.req_data[gi*DATA_W +: DATA_W];
    assign shamt_arr[gi] = bus.req_shamt[gi*SHAMT_W +: SHAMT_W];
  end

  // First valid requester after ptr, wrapping modulo NUM_REQ.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    ptr);
    logic [NUM_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  always_comb begin
    can_accept = (state_reg == IDLE) || ((state_reg == DONE) && bus.res_ready);
    grant_vec  = can_accept ? rr_pick(bus.req_valid, rr_ptr_reg) : '0;
    accept     = |grant_vec;
    grant_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_vec[k]) grant_idx = ID_W'(k);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (bus.res_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  rotl_unit #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_rotl (
    .op  (op_reg),
    .sh  (sh_reg),
    .res (rot_res)
  );

  // Pointer resets to the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= ID_W'(NUM_REQ - 1);
      op_reg       <= '0;
      sh_reg       <= '0;
      id_reg       <= '0;
      res_data_reg <= '0;
      res_id_reg   <= '0;
    end else begin
      if (accept) begin
        op_reg     <= data_arr[grant_idx];
        sh_reg     <= shamt_arr[grant_idx];
        id_reg     <= grant_idx;
        rr_ptr_reg <= grant_idx;
      end
      if (state_reg == EXEC) begin
        res_data_reg <= rot_res;
        res_id_reg   <= id_reg;
      end
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.res_valid = (state_reg == DONE);
  assign bus.res_data  = res_data_reg;
  assign bus.res_id    = res_id_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rotl_share_arbiter.sv
// Scenario-driven and randomized checks of rotl_share_arbiter against a behavioural model.
module tb_rotl_share_arbiter;
  import rotl_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int SW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotl_share_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .SHAMT_W(SW), .ID_W(IW)) bus();

  rotl_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .SHAMT_W(SW), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Rotation defined bit by bit: bit i of the operand lands at (i+sh) mod 16.
  function automatic logic [15:0] rot_ref(input logic [15:0] op, input int sh);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[(i + sh) % 16] = op[i];
    return r;
  endfunction

  function automatic int pick_ref(input logic [3:0] v, input int ptr);
    int c;
    for (int k = 1; k <= NR; k++) begin
      c = (ptr + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [15:0] d, input int sh);
    logic [3:0] s;
    s = sh[3:0];
    bus.req_data[i*DW +: DW]  = d;
    bus.req_shamt[i*SW +: SW] = s;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_shamt = '0;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_shamt = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.busy} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b data=%h id=%0d busy=%b required all zero",
               bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.busy);
    end
    next_cycle;
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_priority: rdy=%b busy=%b required rdy=0001 busy=0",
               bus.req_ready, bus.busy);
    end
    $display("txn reset: first grant rdy=%b", bus.req_ready);
  endtask

  task automatic test_single;
    do_reset;
    set_req(0, 16'h8001, 1);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: rdy=%b required 0001", bus.req_ready);
    end
    next_cycle;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_exec: rdy=%b rv=%b busy=%b required 0000 0 1",
               bus.req_ready, bus.res_valid, bus.busy);
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0003 || bus.res_id !== 2'd0) begin
      errors++;
      $display("FAIL single_result: rv=%b data=%h id=%0d required 1 0003 0",
               bus.res_valid, bus.res_data, bus.res_id);
    end
    $display("txn single: id=%0d data=%h", bus.res_id, bus.res_data);
    next_cycle;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: rv=%b busy=%b required 0 0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_rotate_values;
    logic [15:0] ops  [4] = '{16'hF00F, 16'hA5A5, 16'h8000, 16'h0001};
    int          shs  [4] = '{4, 0, 15, 15};
    logic [15:0] exps [4] = '{16'h00FF, 16'hA5A5, 16'h4000, 16'h8000};
    do_reset;
    bus.res_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(0, ops[t], shs[t]);
      bus.req_valid = 4'b0001;
      next_cycle;
      bus.req_valid = '0;
      next_cycle;
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exps[t]) begin
        errors++;
        $display("FAIL rotate_%0d: rv=%b data=%h required 1 %h", t, bus.res_valid, bus.res_data, exps[t]);
      end
      $display("txn rotate: op=%h sh=%0d res=%h", ops[t], shs[t], bus.res_data);
      next_cycle;
    end
  endtask

  task automatic test_fairness;
    int          seq [5] = '{0, 1, 2, 3, 0};
    logic [15:0] dat [4] = '{16'h1357, 16'hF0E1, 16'h8421, 16'h7FFE};
    logic [3:0]  exp_rdy;
    int          id;
    do_reset;
    for (int i = 0; i < NR; i++) set_req(i, dat[i], i + 1);
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_rdy = (k % 2 == 0) ? 4'(1 << seq[k/2]) : 4'b0000;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL fair_grant_%0d: rdy=%b required %b", k, bus.req_ready, exp_rdy);
      end
      checks++;
      if (bus.res_valid !== (k >= 2 && k % 2 == 0)) begin
        errors++;
        $display("FAIL fair_valid_%0d: rv=%b required %b", k, bus.res_valid, (k >= 2 && k % 2 == 0));
      end
      if (k >= 2 && k % 2 == 0) begin
        id = seq[k/2 - 1];
        checks++;
        if (bus.res_id !== 2'(id) || bus.res_data !== rot_ref(dat[id], id + 1)) begin
          errors++;
          $display("FAIL fair_result_%0d: id=%0d data=%h required %0d %h",
                   k, bus.res_id, bus.res_data, id, rot_ref(dat[id], id + 1));
        end
        $display("txn fair: id=%0d data=%h", bus.res_id, bus.res_data);
      end
      next_cycle;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    set_req(0, 16'h1234, 0);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    next_cycle;
    bus.req_valid = '0;
    next_cycle;
    set_req(2, 16'h00F0, 2);
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h1234 || bus.res_id !== 2'd0 ||
          bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: rv=%b data=%h id=%0d rdy=%b busy=%b required 1 1234 0 0000 1",
                 k, bus.res_valid, bus.res_data, bus.res_id, bus.req_ready, bus.busy);
      end
      next_cycle;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain_grant: rdy=%b rv=%b required 0100 1", bus.req_ready, bus.res_valid);
    end
    $display("txn backpressure: drained id=%0d data=%h", bus.res_id, bus.res_data);
    next_cycle;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_exec: rv=%b busy=%b required 0 1", bus.res_valid, bus.busy);
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_data !== 16'h03C0) begin
      errors++;
      $display("FAIL bp_next_result: rv=%b id=%0d data=%h required 1 2 03c0",
               bus.res_valid, bus.res_id, bus.res_data);
    end
  endtask

  task automatic test_reset_mid_op;
    do_reset;
    set_req(1, 16'hBEEF, 3);
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b0;
    next_cycle;
    bus.req_valid = '0;
    next_cycle;
    set_req(2, 16'h5555, 1);
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    next_cycle;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.busy} !== 24'h0) begin
      errors++;
      $display("FAIL midop_reset: rdy=%b rv=%b data=%h id=%0d busy=%b required all zero",
               bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.busy);
    end
    next_cycle;
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_regrant: rdy=%b busy=%b required 0001 0", bus.req_ready, bus.busy);
    end
    $display("txn reset_mid_op: regrant rdy=%b", bus.req_ready);
  endtask

  task automatic test_skip;
    do_reset;
    bus.res_ready = 1'b1;
    set_req(0, 16'h0F00, 1);
    set_req(3, 16'h0003, 2);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    next_cycle;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL skip_exec_nogrant: rdy=%b required 0000", bus.req_ready);
    end
    next_cycle;
    bus.req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000 || bus.res_id !== 2'd0 || bus.res_data !== 16'h1E00) begin
      errors++;
      $display("FAIL skip_grant3: rdy=%b id=%0d data=%h required 1000 0 1e00",
               bus.req_ready, bus.res_id, bus.res_data);
    end
    next_cycle;
    bus.req_valid = '0;
    next_cycle;
    bus.req_valid = 4'b0111;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.res_id !== 2'd3 || bus.res_data !== 16'h000C) begin
      errors++;
      $display("FAIL skip_ptr3: rdy=%b id=%0d data=%h required 0001 3 000c",
               bus.req_ready, bus.res_id, bus.res_data);
    end
    $display("txn skip: id=%0d data=%h", bus.res_id, bus.res_data);
  endtask

  task automatic test_random;
    // Model: an accepted operand spends one cycle in flight, then waits as a result until drained.
    int          m_ptr;
    bit          m_inflight, m_has_res, can;
    logic [15:0] m_op, m_res_data;
    int          m_sh, m_id, m_res_id, g;
    logic [3:0]  exp_rdy;
    do_reset;
    m_ptr = NR - 1;
    m_inflight = 1'b0;
    m_has_res = 1'b0;
    m_op = '0; m_sh = 0; m_id = 0; m_res_data = '0; m_res_id = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      bus.req_data  = {$urandom, $urandom};
      bus.req_shamt = 16'($urandom_range(0, 65535));
      @(negedge clk);
      can = !m_inflight && (!m_has_res || bus.res_ready);
      g = can ? pick_ref(bus.req_valid, m_ptr) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++;
      if (bus.req_ready !== exp_rdy || bus.res_valid !== m_has_res ||
          bus.busy !== (m_inflight || m_has_res)) begin
        errors++;
        $display("FAIL rand_ctrl_%0d: rdy=%b rv=%b busy=%b required %b %b %b", cyc,
                 bus.req_ready, bus.res_valid, bus.busy, exp_rdy, m_has_res, (m_inflight || m_has_res));
      end
      if (m_has_res) begin
        checks++;
        if (bus.res_data !== m_res_data || bus.res_id !== 2'(m_res_id)) begin
          errors++;
          $display("FAIL rand_result_%0d: data=%h id=%0d required %h %0d", cyc,
                   bus.res_data, bus.res_id, m_res_data, m_res_id);
        end
        if (bus.res_ready) $display("txn random: id=%0d data=%h", bus.res_id, bus.res_data);
      end
      if (m_inflight) begin
        m_has_res  = 1'b1;
        m_res_data = rot_ref(m_op, m_sh);
        m_res_id   = m_id;
      end else if (m_has_res && bus.res_ready) begin
        m_has_res = 1'b0;
      end
      m_inflight = (g >= 0);
      if (g >= 0) begin
        m_op  = bus.req_data[g*DW +: DW];
        m_sh  = int'(bus.req_shamt[g*SW +: SW]);
        m_id  = g;
        m_ptr = g;
      end
      next_cycle;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotate_values;
    test_fairness;
    test_backpressure;
    test_reset_mid_op;
    test_skip;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
